// File: rtl/pipe_flow_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_flow_pkg
//  Description : Shared types for the pipeline flow controller: FSM state
//                enum, next-PC source codes and a PC increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_flow_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SLEEP = 2'd1,
      DRAIN = 2'd2,
      TRAP  = 2'd3
   } flow_state_e;

   // Next-PC source select codes
   localparam logic [1:0] RSEL_SEQ    = 2'd0;  // PC+4 / predictor
   localparam logic [1:0] RSEL_EXE    = 2'd1;  // branch target resolved in EXE
   localparam logic [1:0] RSEL_TVEC   = 2'd2;  // mtvec
   localparam logic [1:0] RSEL_RESUME = 2'd3;  // resume_pc

   // Sequential PC after a 32-bit instruction; wraps modulo 2^32.
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_unit
//  Description : Combinational hazard detection for the flow controller.
//                Flags a load-use dependency between EXE and ID, and a
//                branch mispredict resolved in EXE with its class.
//  Ports       : id_rs1_i/id_rs2_i, id_use_rs1_i/id_use_rs2_i - ID sources
//                ex_rd_i, ex_is_load_i                        - EXE load
//                ex_branch_i, ex_pred_taken_i, ex_actual_taken_i - branch
//                load_use_o, mispredict_o, nt_pt_o, t_pnt_o   - detections
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit (
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_use_rs1_i,
   input  logic       id_use_rs2_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_is_load_i,
   input  logic       ex_branch_i,
   input  logic       ex_pred_taken_i,
   input  logic       ex_actual_taken_i,
   output logic       load_use_o,
   output logic       mispredict_o,
   output logic       nt_pt_o,
   output logic       t_pnt_o
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
   assign w_rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

   // x0 is never a real producer, so a load to x0 cannot create a hazard.
   assign load_use_o   = ex_is_load_i && (ex_rd_i != 5'd0) && (w_rs1_hit || w_rs2_hit);

   assign mispredict_o = ex_branch_i && (ex_pred_taken_i != ex_actual_taken_i);
   assign nt_pt_o      = mispredict_o && !ex_pred_taken_i;
   assign t_pnt_o      = mispredict_o &&  ex_pred_taken_i;

endmodule
`default_nettype wire

// File: rtl/pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_flow_ctrl
//  Description : Central flow controller for the 5-stage pipeline. Produces
//                hold/bubble/flush controls for IF/ID and ID/EXE, selects the
//                next-PC source, and sequences interrupt drain, WFI sleep and
//                MRET return.
//  Ports       : clk, rst (async, active-high)
//                imem_busy_i/dmem_busy_i  - memory wait, freezes everything
//                id_* / if_pc_i           - decode-stage instruction info
//                ex_*                     - EXE load and branch resolution
//                irq_pending_i/irq_enable_i, csr_mepc_i - CSR inputs
//                freeze_o, pc_hold_o, if_id_hold_o, if_id_flush_o,
//                id_ex_bubble_o           - pipe register controls
//                nt_pt_o/t_pnt_o          - mispredict class
//                redirect_sel_o/resume_pc_o - next-PC source and resume PC
//                take_trap_o/trap_epc_o   - trap entry pulse and saved PC
//                wfi_active_o             - sleeping in WFI
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_flow_ctrl
   import pipe_flow_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 2   // 1..7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_busy_i,
   input  logic        dmem_busy_i,
   input  logic        id_valid_i,
   input  logic [31:0] id_pc_i,
   input  logic [31:0] if_pc_i,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_use_rs1_i,
   input  logic        id_use_rs2_i,
   input  logic        id_is_wfi_i,
   input  logic        id_is_mret_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        ex_is_load_i,
   input  logic        ex_branch_i,
   input  logic        ex_pred_taken_i,
   input  logic        ex_actual_taken_i,
   input  logic        irq_pending_i,
   input  logic        irq_enable_i,
   input  logic [31:0] csr_mepc_i,
   output logic        freeze_o,
   output logic        pc_hold_o,
   output logic        if_id_hold_o,
   output logic        if_id_flush_o,
   output logic        id_ex_bubble_o,
   output logic        nt_pt_o,
   output logic        t_pnt_o,
   output logic [1:0]  redirect_sel_o,
   output logic [31:0] resume_pc_o,
   output logic        take_trap_o,
   output logic [31:0] trap_epc_o,
   output logic        wfi_active_o
);

   localparam logic [2:0] c_drain_init = 3'(DRAIN_CYCLES);

   flow_state_e state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] trap_epc_q, trap_epc_d;
   logic [31:0] wfi_pc_q, wfi_pc_d;

   logic w_load_use;
   logic w_mispredict;
   logic w_nt_pt;
   logic w_t_pnt;
   logic w_irq;

   pipe_hazard_unit u_hazard (
      .id_rs1_i          (id_rs1_i),
      .id_rs2_i          (id_rs2_i),
      .id_use_rs1_i      (id_use_rs1_i),
      .id_use_rs2_i      (id_use_rs2_i),
      .ex_rd_i           (ex_rd_i),
      .ex_is_load_i      (ex_is_load_i),
      .ex_branch_i       (ex_branch_i),
      .ex_pred_taken_i   (ex_pred_taken_i),
      .ex_actual_taken_i (ex_actual_taken_i),
      .load_use_o        (w_load_use),
      .mispredict_o      (w_mispredict),
      .nt_pt_o           (w_nt_pt),
      .t_pnt_o           (w_t_pnt)
   );

   assign freeze_o   = imem_busy_i | dmem_busy_i;
   assign w_irq      = irq_pending_i & irq_enable_i;
   assign trap_epc_o = trap_epc_q;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      trap_epc_d     = trap_epc_q;
      wfi_pc_d       = wfi_pc_q;
      pc_hold_o      = 1'b0;
      if_id_hold_o   = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      nt_pt_o        = 1'b0;
      t_pnt_o        = 1'b0;
      redirect_sel_o = RSEL_SEQ;
      resume_pc_o    = 32'd0;
      take_trap_o    = 1'b0;
      wfi_active_o   = 1'b0;

      // A frozen cycle is invisible: nothing is accepted and nothing moves.
      if (!freeze_o) begin
         case (state_q)
            RUN: begin
               if (w_mispredict) begin
                  // Any pending irq waits one cycle so trap_epc lands on the
                  // corrected path.
                  if_id_flush_o  = 1'b1;
                  id_ex_bubble_o = 1'b1;
                  redirect_sel_o = RSEL_EXE;
                  nt_pt_o        = w_nt_pt;
                  t_pnt_o        = w_t_pnt;
               end else if (w_irq) begin
                  if_id_flush_o  = 1'b1;
                  id_ex_bubble_o = 1'b1;
                  pc_hold_o      = 1'b1;
                  trap_epc_d     = id_valid_i ? id_pc_i : if_pc_i;
                  cnt_d          = c_drain_init;
                  state_d        = DRAIN;
               end else if (id_valid_i && id_is_mret_i) begin
                  if_id_flush_o  = 1'b1;
                  id_ex_bubble_o = 1'b1;
                  redirect_sel_o = RSEL_RESUME;
                  resume_pc_o    = csr_mepc_i;
               end else if (id_valid_i && id_is_wfi_i) begin
                  wfi_pc_d       = id_pc_i;
                  id_ex_bubble_o = 1'b1;
                  if_id_hold_o   = 1'b1;
                  pc_hold_o      = 1'b1;
                  state_d        = SLEEP;
               end else if (w_load_use) begin
                  pc_hold_o      = 1'b1;
                  if_id_hold_o   = 1'b1;
                  id_ex_bubble_o = 1'b1;
               end
            end

            SLEEP: begin
               wfi_active_o   = 1'b1;
               pc_hold_o      = 1'b1;
               if_id_hold_o   = 1'b1;
               id_ex_bubble_o = 1'b1;
               if (irq_pending_i) begin
                  if (irq_enable_i) begin
                     trap_epc_d = pc_next(wfi_pc_q);
                     cnt_d      = c_drain_init;
                     state_d    = DRAIN;
                  end else begin
                     // Masked wake: resume after the WFI without trapping.
                     if_id_flush_o  = 1'b1;
                     redirect_sel_o = RSEL_RESUME;
                     resume_pc_o    = pc_next(wfi_pc_q);
                     state_d        = RUN;
                  end
               end
            end

            DRAIN: begin
               pc_hold_o      = 1'b1;
               if_id_flush_o  = 1'b1;
               id_ex_bubble_o = 1'b1;
               cnt_d          = cnt_q - 3'd1;
               if (cnt_q <= 3'd1) begin
                  state_d = TRAP;
               end
            end

            TRAP: begin
               take_trap_o    = 1'b1;
               redirect_sel_o = RSEL_TVEC;
               if_id_flush_o  = 1'b1;
               id_ex_bubble_o = 1'b1;
               state_d        = RUN;
            end

            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         cnt_q      <= 3'd0;
         trap_epc_q <= 32'd0;
         wfi_pc_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         trap_epc_q <= trap_epc_d;
         wfi_pc_q   <= wfi_pc_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_flow_ctrl
//  Description : Self-checking bench for pipe_flow_ctrl: a vector table for
//                single-cycle RUN behaviour, hand sequences for interrupt
//                drain, WFI, freeze and reset corners, and a random run
//                against a cycle-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_flow_ctrl;

   localparam int D = 2;

   typedef struct packed {
      logic        imem_busy;
      logic        dmem_busy;
      logic        id_valid;
      logic [31:0] id_pc;
      logic [31:0] if_pc;
      logic [4:0]  id_rs1;
      logic [4:0]  id_rs2;
      logic        id_use_rs1;
      logic        id_use_rs2;
      logic        id_is_wfi;
      logic        id_is_mret;
      logic [4:0]  ex_rd;
      logic        ex_is_load;
      logic        ex_branch;
      logic        ex_pred_taken;
      logic        ex_actual_taken;
      logic        irq_pending;
      logic        irq_enable;
      logic [31:0] csr_mepc;
   } in_t;

   typedef struct packed {
      logic       freeze;
      logic       pc_hold;
      logic       if_id_hold;
      logic       if_id_flush;
      logic       id_ex_bubble;
      logic       nt_pt;
      logic       t_pnt;
      logic [1:0] rsel;
      logic       take_trap;
      logic       wfi_active;
   } flg_t;

   typedef struct {
      in_t         i;
      flg_t        e;
      logic [31:0] resume;
   } vec_t;

   logic        clk;
   logic        rst;
   in_t         din;
   flg_t        act;
   logic        freeze, pc_hold, if_id_hold, if_id_flush, id_ex_bubble;
   logic        nt_pt, t_pnt, take_trap, wfi_active;
   logic [1:0]  redirect_sel;
   logic [31:0] resume_pc, trap_epc;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_wait;     // 0 idle; >1 drain cycles left +1; 1 = trap cycle
   bit          m_sleep;
   logic [31:0] m_epc;
   logic [31:0] m_wfipc;

   pipe_flow_ctrl #(.DRAIN_CYCLES(D)) dut (
      .clk               (clk),
      .rst               (rst),
      .imem_busy_i       (din.imem_busy),
      .dmem_busy_i       (din.dmem_busy),
      .id_valid_i        (din.id_valid),
      .id_pc_i           (din.id_pc),
      .if_pc_i           (din.if_pc),
      .id_rs1_i          (din.id_rs1),
      .id_rs2_i          (din.id_rs2),
      .id_use_rs1_i      (din.id_use_rs1),
      .id_use_rs2_i      (din.id_use_rs2),
      .id_is_wfi_i       (din.id_is_wfi),
      .id_is_mret_i      (din.id_is_mret),
      .ex_rd_i           (din.ex_rd),
      .ex_is_load_i      (din.ex_is_load),
      .ex_branch_i       (din.ex_branch),
      .ex_pred_taken_i   (din.ex_pred_taken),
      .ex_actual_taken_i (din.ex_actual_taken),
      .irq_pending_i     (din.irq_pending),
      .irq_enable_i      (din.irq_enable),
      .csr_mepc_i        (din.csr_mepc),
      .freeze_o          (freeze),
      .pc_hold_o         (pc_hold),
      .if_id_hold_o      (if_id_hold),
      .if_id_flush_o     (if_id_flush),
      .id_ex_bubble_o    (id_ex_bubble),
      .nt_pt_o           (nt_pt),
      .t_pnt_o           (t_pnt),
      .redirect_sel_o    (redirect_sel),
      .resume_pc_o       (resume_pc),
      .take_trap_o       (take_trap),
      .trap_epc_o        (trap_epc),
      .wfi_active_o      (wfi_active)
   );

   assign act = {freeze, pc_hold, if_id_hold, if_id_flush, id_ex_bubble,
                 nt_pt, t_pnt, redirect_sel, take_trap, wfi_active};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic flg_t mkf(input logic fz, ph, ih, fl, bb, nt, tp,
                                input logic [1:0] rs, input logic tt, wa);
      flg_t f;
      f = {fz, ph, ih, fl, bb, nt, tp, rs, tt, wa};
      return f;
   endfunction

   function automatic in_t idle();
      in_t t;
      t = '0;
      return t;
   endfunction

   task automatic check_flags(input string nm, input flg_t e);
      total++;
      if (act !== e) begin
         bad++;
         $display("FAIL %s flags got=%b want=%b (fz,ph,ih,fl,bb,nt,tp,rs[2],tt,wa)",
                  nm, act, e);
      end
   endtask

   task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check at the falling edge, then advance past the next rising edge.
   task automatic step(input string nm, input flg_t e, input bit chk_res,
                       input logic [31:0] res, input bit chk_epc, input logic [31:0] epc);
      @(negedge clk);
      check_flags(nm, e);
      if (chk_res) check32({nm, "_resume"}, resume_pc, res);
      if (chk_epc) check32({nm, "_epc"}, trap_epc, epc);
      tick();
   endtask

   task automatic model_reset();
      m_wait  = 0;
      m_sleep = 0;
      m_epc   = 32'd0;
      m_wfipc = 32'd0;
   endtask

   // Expected outputs for this cycle, and the model's advance to the next.
   task automatic model_step(input in_t x, output flg_t e, output logic [31:0] er);
      bit mis, irq, lu;
      e  = '0;
      er = 32'd0;
      mis = x.ex_branch && (x.ex_pred_taken != x.ex_actual_taken);
      irq = x.irq_pending && x.irq_enable;
      lu  = x.ex_is_load && (x.ex_rd != 0) &&
            ((x.id_use_rs1 && x.id_rs1 == x.ex_rd) || (x.id_use_rs2 && x.id_rs2 == x.ex_rd));
      if (x.imem_busy || x.dmem_busy) begin
         e.freeze = 1'b1;
      end else if (m_wait == 1) begin
         e.take_trap = 1'b1; e.rsel = 2'd2; e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1;
         m_wait = 0;
      end else if (m_wait > 1) begin
         e.pc_hold = 1'b1; e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1;
         m_wait--;
      end else if (m_sleep) begin
         e.wfi_active = 1'b1; e.pc_hold = 1'b1; e.if_id_hold = 1'b1; e.id_ex_bubble = 1'b1;
         if (x.irq_pending) begin
            m_sleep = 0;
            if (x.irq_enable) begin
               m_wait = D + 1;
               m_epc  = m_wfipc + 32'd4;
            end else begin
               e.if_id_flush = 1'b1; e.rsel = 2'd3;
               er = m_wfipc + 32'd4;
            end
         end
      end else if (mis) begin
         e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1; e.rsel = 2'd1;
         e.nt_pt = !x.ex_pred_taken; e.t_pnt = x.ex_pred_taken;
      end else if (irq) begin
         e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1; e.pc_hold = 1'b1;
         m_epc  = x.id_valid ? x.id_pc : x.if_pc;
         m_wait = D + 1;
      end else if (x.id_valid && x.id_is_mret) begin
         e.if_id_flush = 1'b1; e.id_ex_bubble = 1'b1; e.rsel = 2'd3;
         er = x.csr_mepc;
      end else if (x.id_valid && x.id_is_wfi) begin
         e.id_ex_bubble = 1'b1; e.if_id_hold = 1'b1; e.pc_hold = 1'b1;
         m_wfipc = x.id_pc;
         m_sleep = 1;
      end else if (lu) begin
         e.pc_hold = 1'b1; e.if_id_hold = 1'b1; e.id_ex_bubble = 1'b1;
      end
   endtask

   vec_t vt[17];
   flg_t Z, LU, DR, TR, SL;

   initial begin
      in_t t;
      Z  = mkf(0,0,0,0,0,0,0,2'd0,0,0);
      LU = mkf(0,1,1,0,1,0,0,2'd0,0,0);
      DR = mkf(0,1,0,1,1,0,0,2'd0,0,0);
      TR = mkf(0,0,0,1,1,0,0,2'd2,1,0);
      SL = mkf(0,1,1,0,1,0,0,2'd0,0,1);

      // ---------------- vector table (single-cycle RUN behaviour) --------
      t = idle();                                   vt[0]  = '{t, Z, 32'd0};
      t = idle(); t.ex_is_load = 1; t.ex_rd = 5; t.id_rs2 = 5; t.id_use_rs2 = 1;
                                                    vt[1]  = '{t, LU, 32'd0};
      t = idle(); t.ex_is_load = 1; t.ex_rd = 5; t.id_rs1 = 5; t.id_use_rs1 = 1;
                                                    vt[2]  = '{t, LU, 32'd0};
      t = idle(); t.ex_is_load = 1; t.ex_rd = 0; t.id_rs1 = 0; t.id_use_rs1 = 1;
                                                    vt[3]  = '{t, Z, 32'd0};
      t = idle(); t.ex_is_load = 1; t.ex_rd = 5; t.id_rs1 = 5; t.id_use_rs1 = 0;
                                                    vt[4]  = '{t, Z, 32'd0};
      t = idle(); t.ex_is_load = 0; t.ex_rd = 5; t.id_rs1 = 5; t.id_use_rs1 = 1;
                                                    vt[5]  = '{t, Z, 32'd0};
      t = idle(); t.ex_branch = 1; t.ex_pred_taken = 0; t.ex_actual_taken = 1;
                                                    vt[6]  = '{t, mkf(0,0,0,1,1,1,0,2'd1,0,0), 32'd0};
      t = idle(); t.ex_branch = 1; t.ex_pred_taken = 1; t.ex_actual_taken = 0;
                                                    vt[7]  = '{t, mkf(0,0,0,1,1,0,1,2'd1,0,0), 32'd0};
      t = idle(); t.ex_branch = 1; t.ex_pred_taken = 1; t.ex_actual_taken = 1;
                                                    vt[8]  = '{t, Z, 32'd0};
      t = idle(); t.id_valid = 1; t.id_is_mret = 1; t.csr_mepc = 32'h8000_0040;
                                                    vt[9]  = '{t, mkf(0,0,0,1,1,0,0,2'd3,0,0), 32'h8000_0040};
      t = idle(); t.id_valid = 0; t.id_is_mret = 1; t.csr_mepc = 32'h8000_0040;
                                                    vt[10] = '{t, Z, 32'd0};
      t = idle(); t.id_valid = 1; t.id_is_mret = 1; t.csr_mepc = 32'h0000_1230;
      t.ex_is_load = 1; t.ex_rd = 7; t.id_rs1 = 7; t.id_use_rs1 = 1;
                                                    vt[11] = '{t, mkf(0,0,0,1,1,0,0,2'd3,0,0), 32'h0000_1230};
      t = idle(); t.id_valid = 1; t.id_is_mret = 1; t.ex_branch = 1; t.ex_actual_taken = 1;
                                                    vt[12] = '{t, mkf(0,0,0,1,1,1,0,2'd1,0,0), 32'd0};
      t = idle(); t.imem_busy = 1; t.ex_branch = 1; t.ex_actual_taken = 1;
                                                    vt[13] = '{t, mkf(1,0,0,0,0,0,0,2'd0,0,0), 32'd0};
      t = idle(); t.dmem_busy = 1; t.ex_is_load = 1; t.ex_rd = 5; t.id_rs2 = 5; t.id_use_rs2 = 1;
                                                    vt[14] = '{t, mkf(1,0,0,0,0,0,0,2'd0,0,0), 32'd0};
      t = idle(); t.id_valid = 0; t.id_is_wfi = 1;  vt[15] = '{t, Z, 32'd0};
      t = idle(); t.id_valid = 1; t.id_is_wfi = 1; t.ex_branch = 1; t.ex_pred_taken = 1;
                                                    vt[16] = '{t, mkf(0,0,0,1,1,0,1,2'd1,0,0), 32'd0};

      // ---------------- reset state ----------------
      din = idle();
      rst = 1'b1;
      @(negedge clk);
      check_flags("reset_flags", Z);
      check32("reset_trap_epc", trap_epc, 32'd0);
      tick();
      rst = 1'b0;

      for (int k = 0; k < 17; k++) begin
         din = vt[k].i;
         step($sformatf("vec%0d", k), vt[k].e, vt[k].e.rsel == 2'd3, vt[k].resume, 0, 0);
      end

      // ---- load-use lasts one cycle, then the bubble has left EXE ----
      din = vt[1].i;
      step("lu_stall", LU, 0, 0, 0, 0);
      din = idle(); din.id_rs2 = 5; din.id_use_rs2 = 1;
      step("lu_after", Z, 0, 0, 0, 0);

      // ---- irq at id_pc=0x100, mispredict ignored while draining ----
      din = idle(); din.id_valid = 1; din.id_pc = 32'h100; din.irq_pending = 1; din.irq_enable = 1;
      step("irq_accept", DR, 0, 0, 0, 0);
      din.ex_branch = 1; din.ex_actual_taken = 1;
      for (int k = 0; k < D; k++) step($sformatf("irq_drain%0d", k), DR, 0, 0, 0, 0);
      din.ex_branch = 0;
      step("irq_trap", TR, 0, 0, 1, 32'h100);
      din = idle();
      step("irq_after", Z, 0, 0, 0, 0);

      // ---- freeze for 3 cycles mid-drain delays the trap by 3 ----
      din = idle(); din.if_pc = 32'h300; din.irq_pending = 1; din.irq_enable = 1;
      step("frz_accept", DR, 0, 0, 0, 0);
      step("frz_drain0", DR, 0, 0, 0, 0);
      din.dmem_busy = 1;
      for (int k = 0; k < 3; k++) step($sformatf("frz_busy%0d", k), mkf(1,0,0,0,0,0,0,2'd0,0,0), 0, 0, 0, 0);
      din.dmem_busy = 0;
      for (int k = 1; k < D; k++) step($sformatf("frz_drain%0d", k), DR, 0, 0, 0, 0);
      step("frz_trap", TR, 0, 0, 1, 32'h300);
      din = idle();

      // ---- mispredict together with irq: irq taken on the next cycle ----
      din = idle(); din.id_valid = 1; din.id_pc = 32'h500; din.if_pc = 32'h400;
      din.ex_branch = 1; din.ex_actual_taken = 1; din.irq_pending = 1; din.irq_enable = 1;
      step("mis_irq_mis", mkf(0,0,0,1,1,1,0,2'd1,0,0), 0, 0, 0, 0);
      din.ex_branch = 0; din.id_valid = 0;
      step("mis_irq_accept", DR, 0, 0, 0, 0);
      for (int k = 0; k < D; k++) step($sformatf("mis_irq_drain%0d", k), DR, 0, 0, 0, 0);
      step("mis_irq_trap", TR, 0, 0, 1, 32'h400);
      din = idle();

      // ---- WFI at 0x200, masked wake after 5 sleep cycles ----
      din = idle(); din.id_valid = 1; din.id_is_wfi = 1; din.id_pc = 32'h200;
      step("wfi_enter", LU, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) step($sformatf("wfi_sleep%0d", k), SL, 0, 0, 0, 0);
      din.irq_pending = 1;
      step("wfi_wake_masked", mkf(0,1,1,1,1,0,0,2'd3,0,1), 1, 32'h204, 0, 0);
      din = idle();
      step("wfi_after", Z, 0, 0, 0, 0);

      // ---- WFI at 0x200, enabled wake -> trap with epc 0x204 ----
      din = idle(); din.id_valid = 1; din.id_is_wfi = 1; din.id_pc = 32'h200;
      step("wfi2_enter", LU, 0, 0, 0, 0);
      step("wfi2_sleep", SL, 0, 0, 0, 0);
      din.irq_pending = 1; din.irq_enable = 1;
      step("wfi2_wake", SL, 0, 0, 0, 0);
      for (int k = 0; k < D; k++) step($sformatf("wfi2_drain%0d", k), DR, 0, 0, 0, 0);
      step("wfi2_trap", TR, 0, 0, 1, 32'h204);
      din = idle();

      // ---- WFI at the top of the address space: resume wraps to 0 ----
      din = idle(); din.id_valid = 1; din.id_is_wfi = 1; din.id_pc = 32'hFFFF_FFFC;
      step("wrap_enter", LU, 0, 0, 0, 0);
      din.irq_pending = 1;
      step("wrap_wake", mkf(0,1,1,1,1,0,0,2'd3,0,1), 1, 32'd0, 0, 0);
      din = idle();

      // ---- reset mid-drain: back to RUN, no trap ever ----
      din = idle(); din.id_valid = 1; din.id_pc = 32'h600; din.irq_pending = 1; din.irq_enable = 1;
      step("rst_accept", DR, 0, 0, 0, 0);
      din.irq_enable = 0;
      @(negedge clk);
      check_flags("rst_drain0", DR);
      tick();
      din = idle();
      rst = 1'b1;
      step("rst_during", Z, 0, 0, 1, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < D + 2; k++) step($sformatf("rst_after%0d", k), Z, 0, 0, 0, 0);

      // ---------------- randomized run against the model ----------------
      model_reset();
      for (int n = 0; n < 4000; n++) begin
         flg_t        e;
         logic [31:0] er;
         in_t         x;
         bit          do_rst;
         do_rst = ($urandom_range(0, 299) == 0);
         x = idle();
         if (!do_rst) begin
            x.imem_busy       = ($urandom_range(0, 99) < 8);
            x.dmem_busy       = ($urandom_range(0, 99) < 8);
            x.id_valid        = ($urandom_range(0, 99) < 80);
            x.id_pc           = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            x.if_pc           = $urandom & 32'hFFFF_FFFC;
            x.id_rs1          = 5'($urandom_range(0, 3));
            x.id_rs2          = 5'($urandom_range(0, 3));
            x.id_use_rs1      = 1'($urandom_range(0, 1));
            x.id_use_rs2      = 1'($urandom_range(0, 1));
            x.id_is_wfi       = ($urandom_range(0, 99) < 5);
            x.id_is_mret      = ($urandom_range(0, 99) < 6);
            x.ex_rd           = 5'($urandom_range(0, 3));
            x.ex_is_load      = ($urandom_range(0, 99) < 40);
            x.ex_branch       = ($urandom_range(0, 99) < 25);
            x.ex_pred_taken   = 1'($urandom_range(0, 1));
            x.ex_actual_taken = 1'($urandom_range(0, 1));
            x.irq_pending     = ($urandom_range(0, 99) < 10);
            x.irq_enable      = ($urandom_range(0, 99) < 60);
            x.csr_mepc        = $urandom;
         end
         din = x;
         rst = do_rst;
         if (do_rst) model_reset();
         @(negedge clk);
         model_step(x, e, er);
         if (do_rst) model_reset();
         check_flags($sformatf("rnd%0d", n), e);
         if (e.rsel == 2'd3 && !do_rst) check32($sformatf("rnd%0d_resume", n), resume_pc, er);
         if (e.take_trap)               check32($sformatf("rnd%0d_epc", n), trap_epc, m_epc);
         tick();
         rst = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
